// File: rtl/scan_chain_element.sv
// Far-end scan chain responder: shifts a frame in MSB-first, applies it to the
// user design on a latch edge, captures the design's outputs and shifts them out.
module scan_chain_element #(
  parameter int NUM_IOS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_clk_in,
  input  logic               scan_data_in,
  input  logic               scan_select_in,
  input  logic               scan_latch_enable_in,
  output logic               scan_clk_out,
  output logic               scan_data_out,
  output logic               scan_select_out,
  output logic               scan_latch_enable_out,
  output logic [NUM_IOS-1:0] design_inputs,
  input  logic [NUM_IOS-1:0] design_outputs,
  output logic               frame_error
);

  localparam int CW = $clog2(NUM_IOS);
  localparam logic [CW-1:0] LastBit = CW'(NUM_IOS - 1);

  logic               clk_q, clk_d;
  logic               sel_q, sel_d;
  logic               le_q, le_d;
  logic [NUM_IOS-1:0] sr_q, sr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_IOS-1:0] di_q, di_d;
  logic               sdo_q, sdo_d;
  logic               fe_q, fe_d;

  logic rise, fall, cap, lat, shift;

  // Scan lines are plain data in the clk domain; edges come from the delayed copies.
  always_comb begin
    rise  = scan_clk_in & ~clk_q;
    fall  = ~scan_clk_in & clk_q;
    cap   = ~scan_select_in & sel_q;
    lat   = scan_latch_enable_in & ~le_q;
    shift = rise & scan_select_in;
  end

  always_comb begin
    clk_d = scan_clk_in;
    sel_d = scan_select_in;
    le_d  = scan_latch_enable_in;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    di_d  = di_q;
    sdo_d = sdo_q;
    fe_d  = fe_q;

    // Capture overrides a shift; the latch always sees the pre-update register.
    if (cap) begin
      sr_d = design_outputs;
    end else if (shift) begin
      sr_d  = {sr_q[NUM_IOS-2:0], scan_data_in};
      cnt_d = (cnt_q == LastBit) ? '0 : cnt_q + 1'b1;
    end

    if (fall) begin
      sdo_d = sr_q[NUM_IOS-1];
    end
    if (cap) begin
      sdo_d = design_outputs[NUM_IOS-1];
    end

    if (lat) begin
      di_d = sr_q;
      if (cnt_q != '0) begin
        fe_d = 1'b1;
      end
    end

    if (cap || lat) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_q <= 1'b0;
      sel_q <= 1'b0;
      le_q  <= 1'b0;
      sr_q  <= '0;
      cnt_q <= '0;
      di_q  <= '0;
      sdo_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      clk_q <= clk_d;
      sel_q <= sel_d;
      le_q  <= le_d;
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      di_q  <= di_d;
      sdo_q <= sdo_d;
      fe_q  <= fe_d;
    end
  end

  assign scan_clk_out          = clk_q;
  assign scan_select_out       = sel_q;
  assign scan_latch_enable_out = le_q;
  assign scan_data_out         = sdo_q;
  assign design_inputs         = di_q;
  assign frame_error           = fe_q;

endmodule

// File: tb/tb_scan_chain_element.sv
// Two daisy-chained scan_chain_element instances checked every cycle against an
// event-level model, plus directed load/capture/chain/partial-frame scenarios.
module tb_scan_chain_element;

  localparam int N = 8;
  localparam int Modulus = 1 << N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN = 1'b0;
  logic scanClk = 1'b0, scanSel = 1'b0, scanLe = 1'b0, scanData = 1'b0;
  logic [N-1:0] dout0 = '0, dout1 = '0;

  logic chainClk, chainData, chainSel, chainLe;
  logic tailClk, tailData, tailSel, tailLe;
  logic [N-1:0] di0, di1;
  logic fe0, fe1;

  scan_chain_element #(.NUM_IOS(N)) u0 (
    .clk(clk), .reset(resetN),
    .scan_clk_in(scanClk), .scan_data_in(scanData),
    .scan_select_in(scanSel), .scan_latch_enable_in(scanLe),
    .scan_clk_out(chainClk), .scan_data_out(chainData),
    .scan_select_out(chainSel), .scan_latch_enable_out(chainLe),
    .design_inputs(di0), .design_outputs(dout0), .frame_error(fe0)
  );

  scan_chain_element #(.NUM_IOS(N)) u1 (
    .clk(clk), .reset(resetN),
    .scan_clk_in(chainClk), .scan_data_in(chainData),
    .scan_select_in(chainSel), .scan_latch_enable_in(chainLe),
    .scan_clk_out(tailClk), .scan_data_out(tailData),
    .scan_select_out(tailSel), .scan_latch_enable_out(tailLe),
    .design_inputs(di1), .design_outputs(dout1), .frame_error(fe1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state per instance: register value as a number, frame count,
  // and the previous level of each scan line (which is also what gets forwarded).
  int mSr[2], mCnt[2], mDi[2], mSdo[2], mFe[2], mPc[2], mPs[2], mPl[2];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep();
    int inC[2], inS[2], inL[2], inD[2], dout[2];
    bit rise, fall, cap, lat;
    int oldSr;
    inC[0] = int'(scanClk); inS[0] = int'(scanSel); inL[0] = int'(scanLe); inD[0] = int'(scanData);
    inC[1] = mPc[0]; inS[1] = mPs[0]; inL[1] = mPl[0]; inD[1] = mSdo[0];
    dout[0] = int'(dout0); dout[1] = int'(dout1);
    for (int k = 0; k < 2; k++) begin
      if (!resetN) begin
        mSr[k] = 0; mCnt[k] = 0; mDi[k] = 0; mSdo[k] = 0; mFe[k] = 0;
        mPc[k] = 0; mPs[k] = 0; mPl[k] = 0;
      end else begin
        rise  = (inC[k] == 1) && (mPc[k] == 0);
        fall  = (inC[k] == 0) && (mPc[k] == 1);
        cap   = (inS[k] == 0) && (mPs[k] == 1);
        lat   = (inL[k] == 1) && (mPl[k] == 0);
        oldSr = mSr[k];
        if (lat) begin
          mDi[k] = oldSr;
          if (mCnt[k] != 0) mFe[k] = 1;
        end
        if (fall) mSdo[k] = oldSr / (Modulus / 2);
        if (cap) begin
          mSr[k]  = dout[k];
          mSdo[k] = dout[k] / (Modulus / 2);
        end else if (rise && inS[k] == 1) begin
          mSr[k]  = (oldSr * 2 + inD[k]) % Modulus;
          mCnt[k] = (mCnt[k] + 1) % N;
        end
        if (cap || lat) mCnt[k] = 0;
        mPc[k] = inC[k]; mPs[k] = inS[k]; mPl[k] = inL[k];
      end
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic c, input logic s,
                               input logic l, input logic d);
    resetN = rstN; scanClk = c; scanSel = s; scanLe = l; scanData = d;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("u0_sdo", int'(chainData), mSdo[0]);
    checkOutput("u0_di", int'(di0), mDi[0]);
    checkOutput("u0_fe", int'(fe0), mFe[0]);
    checkOutput("u0_fwd", int'({chainClk, chainSel, chainLe}), mPc[0] * 4 + mPs[0] * 2 + mPl[0]);
    checkOutput("u1_sdo", int'(tailData), mSdo[1]);
    checkOutput("u1_di", int'(di1), mDi[1]);
    checkOutput("u1_fe", int'(fe1), mFe[1]);
    checkOutput("u1_fwd", int'({tailClk, tailSel, tailLe}), mPc[1] * 4 + mPs[1] * 2 + mPl[1]);
  endtask

  task automatic shiftByte(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, v[i]);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, v[i]);
    end
  endtask

  task automatic pulseLatch();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, i[0], ~i[0], i[0], 1'b1);
    end
  endtask

  bit expSeq[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [N-1:0] capV, preV;

  initial begin
    doReset();
    checkOutput("reset_di0", int'(di0), 0);
    checkOutput("reset_sdo0", int'(chainData), 0);
    checkOutput("reset_fe0", int'(fe0), 0);
    checkOutput("reset_di1", int'(di1), 0);
    checkOutput("reset_fwd1", int'({tailClk, tailSel, tailLe}), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    shiftByte(8'h12);
    shiftByte(8'h34);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulseLatch();
    checkOutput("chain_di0", int'(di0), 'h34);
    checkOutput("chain_di1", int'(di1), 'h12);
    checkOutput("chain_fe1", int'(fe1), 0);

    shiftByte(8'hA5);
    pulseLatch();
    checkOutput("load_a5", int'(di0), 'hA5);
    checkOutput("load_fe", int'(fe0), 0);

    dout0 = 8'h3C;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cap_bit7", int'(chainData), 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("read_bit%0d", i), int'(chainData), int'(expSeq[i]));
    end

    capV  = N'($urandom);
    dout0 = capV;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("cap_rise_noshift", int'(di0), int'(capV));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    preV = N'($urandom);
    shiftByte(preV);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("lat_rise_preshift", int'(di0), int'(preV));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("lat_rise_fe", int'(fe0), 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) dout0 = N'($urandom);
      if ($urandom_range(0, 7) == 0) dout1 = N'($urandom);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    doReset();
    checkOutput("rst_fe_clear", int'(fe0), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    pulseLatch();
    checkOutput("partial_fe", int'(fe0), 1);
    shiftByte(8'h5A);
    pulseLatch();
    checkOutput("good_after_partial_di", int'(di0), 'h5A);
    checkOutput("sticky_fe", int'(fe0), 1);

    doReset();
    checkOutput("final_fe", int'(fe0), 0);
    checkOutput("final_di", int'(di0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
